// File: rtl/seg_to_hex_decode_de1soc_pkg.sv
// rtl/seg_to_hex_decode_de1soc_pkg.sv - glyph constants, types and decode helper for the display monitor
package seg_decode_pkg;

    // Active-high glyph patterns, bit 0 = seg a ... bit 6 = seg g
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} mon_state_t;

    typedef struct packed {
        logic [3:0] nibble;
        logic       valid;
        logic       blank;
    } digit_dec_t;

    // Aliased glyphs (O, S, ...) resolve to their hex meaning; anything unrecognised is all-zero
    function automatic digit_dec_t decode_glyph(input logic [6:0] p);
        digit_dec_t d;
        d = '{nibble: 4'h0, valid: 1'b0, blank: 1'b0};
        case (p)
            SEG_0:     begin d.nibble = 4'h0; d.valid = 1'b1; end
            SEG_1:     begin d.nibble = 4'h1; d.valid = 1'b1; end
            SEG_2:     begin d.nibble = 4'h2; d.valid = 1'b1; end
            SEG_3:     begin d.nibble = 4'h3; d.valid = 1'b1; end
            SEG_4:     begin d.nibble = 4'h4; d.valid = 1'b1; end
            SEG_5:     begin d.nibble = 4'h5; d.valid = 1'b1; end
            SEG_6:     begin d.nibble = 4'h6; d.valid = 1'b1; end
            SEG_7:     begin d.nibble = 4'h7; d.valid = 1'b1; end
            SEG_8:     begin d.nibble = 4'h8; d.valid = 1'b1; end
            SEG_9:     begin d.nibble = 4'h9; d.valid = 1'b1; end
            SEG_A:     begin d.nibble = 4'hA; d.valid = 1'b1; end
            SEG_B:     begin d.nibble = 4'hB; d.valid = 1'b1; end
            SEG_C:     begin d.nibble = 4'hC; d.valid = 1'b1; end
            SEG_D:     begin d.nibble = 4'hD; d.valid = 1'b1; end
            SEG_E:     begin d.nibble = 4'hE; d.valid = 1'b1; end
            SEG_F:     begin d.nibble = 4'hF; d.valid = 1'b1; end
            SEG_BLANK: d.blank = 1'b1;
            default:   d = '{nibble: 4'h0, valid: 1'b0, blank: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/seg_to_hex_decode_de1soc_if.sv
// rtl/seg_to_hex_decode_de1soc_if.sv - decoded frame output bus with valid/ready handshake
interface seg_to_hex_decode_de1soc_if #(
    parameter int NUM_DIGITS = 6
);
    logic [NUM_DIGITS*4-1:0] hex_value_o;
    logic [NUM_DIGITS-1:0]   digit_valid_o;
    logic [NUM_DIGITS-1:0]   digit_blank_o;
    logic                    frame_valid_o;
    logic                    frame_ready_i;

    modport master (
        output hex_value_o,
        output digit_valid_o,
        output digit_blank_o,
        output frame_valid_o,
        input  frame_ready_i
    );

    modport slave (
        input  hex_value_o,
        input  digit_valid_o,
        input  digit_blank_o,
        input  frame_valid_o,
        output frame_ready_i
    );
endinterface

// File: rtl/seg_to_hex_decode_de1soc_filter.sv
// rtl/seg_to_hex_decode_de1soc_filter.sv - per-digit glitch filter and glyph decode
module seg_digit_filter
    import seg_decode_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [6:0] seg,
    output logic       stable,
    output logic [6:0] seg_q,
    output digit_dec_t dec
);
    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

    logic [7:0] cnt;

    // Sample the slice every edge; count consecutive repeats, saturating at the stability threshold
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            seg_q <= '1;
            cnt   <= '0;
        end else begin
            seg_q <= seg;
            if (seg == seg_q) begin
                if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
            end else begin
                cnt <= '0;
            end
        end
    end

    assign stable = (cnt == CNT_MAX);
    assign dec    = decode_glyph(~seg_q);
endmodule

// File: rtl/seg_to_hex_decode_de1soc.sv
// rtl/seg_to_hex_decode_de1soc.sv - 7-segment bus monitor emitting one decoded frame per stable change
module seg_to_hex_decode_de1soc
    import seg_decode_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [NUM_DIGITS*7-1:0] segment_i,
    seg_to_hex_decode_de1soc_if.master mon
);
    logic [NUM_DIGITS-1:0]   stable_vec;
    logic [NUM_DIGITS*7-1:0] seg_q_vec;
    digit_dec_t              dec_arr [NUM_DIGITS];
    logic [NUM_DIGITS*4-1:0] nibble_vec;
    logic [NUM_DIGITS-1:0]   valid_vec;
    logic [NUM_DIGITS-1:0]   blank_vec;

    logic [NUM_DIGITS*7-1:0] last_q;
    logic                    first_q;
    mon_state_t              state_q;
    mon_state_t              state_d;
    logic                    new_frame;
    logic                    commit;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg_digit_filter #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_filter (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .seg     (segment_i[7*k +: 7]),
            .stable  (stable_vec[k]),
            .seg_q   (seg_q_vec[7*k +: 7]),
            .dec     (dec_arr[k])
        );
    end

    // Flatten per-digit decode results into frame-wide vectors
    always_comb begin
        nibble_vec = '0;
        valid_vec  = '0;
        blank_vec  = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nibble_vec[4*k +: 4] = dec_arr[k].nibble;
            valid_vec[k]         = dec_arr[k].valid;
            blank_vec[k]         = dec_arr[k].blank;
        end
    end

    // A frame is worth reporting once everything has settled and it is new (or the first one)
    assign new_frame = (&stable_vec) && (first_q || (seg_q_vec != last_q));

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state: wait for a new stable frame, then hold it until the consumer takes it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (new_frame)         state_d = PEND;
            PEND:    if (mon.frame_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: commit strobe in IDLE, valid while a frame is pending
    always_comb begin
        commit            = (state_q == IDLE) && new_frame;
        mon.frame_valid_o = (state_q == PEND);
    end

    // Frame registers and change-detection snapshot, loaded only on commit
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mon.hex_value_o   <= '0;
            mon.digit_valid_o <= '0;
            mon.digit_blank_o <= '0;
            last_q            <= '0;
            first_q           <= 1'b1;
        end else if (commit) begin
            mon.hex_value_o   <= nibble_vec;
            mon.digit_valid_o <= valid_vec;
            mon.digit_blank_o <= blank_vec;
            last_q            <= seg_q_vec;
            first_q           <= 1'b0;
        end
    end
endmodule

// File: tb/tb_seg_to_hex_decode_de1soc.sv
// tb/tb_seg_to_hex_decode_de1soc.sv - self-checking bench for seg_to_hex_decode_de1soc
module tb_seg_to_hex_decode_de1soc;
    localparam int ND = 6;
    localparam int S  = 4;
    localparam int W  = ND * 7;

    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic [W-1:0] segment_i;

    seg_to_hex_decode_de1soc_if #(.NUM_DIGITS(ND)) mon ();

    seg_to_hex_decode_de1soc #(
        .NUM_DIGITS    (ND),
        .STABLE_CYCLES (S)
    ) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .segment_i (segment_i),
        .mon       (mon)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: history of sampled vectors, newest last
    logic [W-1:0]    hist [$];
    bit              m_pend;
    bit              m_first;
    logic [W-1:0]    m_last;
    logic [ND*4-1:0] m_hex;
    logic [ND-1:0]   m_val;
    logic [ND-1:0]   m_blk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        hist.delete();
        hist.push_back('1);
        m_pend  = 1'b0;
        m_first = 1'b1;
        m_last  = '0;
        m_hex   = '0;
        m_val   = '0;
        m_blk   = '0;
    endtask

    // Stable when the last S samples (reset value counts as one) are identical
    function automatic bit m_stable();
        int n;
        n = hist.size();
        if (n < S) return 1'b0;
        for (int i = 1; i < S; i++)
            if (hist[n-1-i] != hist[n-1]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_edge(input logic rdy, input logic [W-1:0] seg);
        logic [W-1:0] cur;
        logic [6:0]   p;
        bit           hit;
        cur = hist[hist.size()-1];
        if (m_pend) begin
            if (rdy) m_pend = 1'b0;
        end else if (m_stable() && (m_first || cur != m_last)) begin
            m_pend  = 1'b1;
            m_first = 1'b0;
            m_last  = cur;
            for (int k = 0; k < ND; k++) begin
                p   = ~cur[7*k +: 7];
                hit = 1'b0;
                m_hex[4*k +: 4] = 4'h0;
                for (int j = 0; j < 16; j++)
                    if (glyph[j] == p) begin
                        hit = 1'b1;
                        m_hex[4*k +: 4] = 4'(j);
                    end
                m_val[k] = hit;
                m_blk[k] = (p == 7'h00);
            end
        end
        hist.push_back(seg);
        if (hist.size() > S) void'(hist.pop_front());
    endtask

    task automatic check_all();
        chk("frame_valid", 32'(mon.frame_valid_o), 32'(m_pend));
        chk("hex_value", 32'(mon.hex_value_o), 32'(m_hex));
        chk("digit_valid", 32'(mon.digit_valid_o), 32'(m_val));
        chk("digit_blank", 32'(mon.digit_blank_o), 32'(m_blk));
    endtask

    task automatic step(input logic [W-1:0] seg, input logic rdy);
        segment_i         = seg;
        mon.frame_ready_i = rdy;
        @(posedge clk_i);
        m_edge(rdy, seg);
        @(negedge clk_i);
        check_all();
    endtask

    function automatic logic [W-1:0] rnd_vec();
        logic [W-1:0] v;
        int           r;
        v = '0;
        for (int k = 0; k < ND; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      v[7*k +: 7] = ~glyph[$urandom_range(0, 3)];
            else if (r < 8) v[7*k +: 7] = 7'h7F;
            else            v[7*k +: 7] = ~7'($urandom_range(1, 127));
        end
        return v;
    endfunction

    logic [W-1:0] ones_v, v_v, g_v, a_v, h_v, e_v, rv, gv;
    int           idx;

    initial begin
        ones_v = '1;
        v_v    = ~{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
        g_v    = ~{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h06};
        a_v    = ~{7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h77};
        h_v    = ~{7'h6D, 7'h66, 7'h4F, 7'h76, 7'h06, 7'h77};
        e_v    = ~{7'h6D, 7'h66, 7'h4F, 7'h76, 7'h7F, 7'h77};

        // Reset state
        rst_n_i           = 1'b0;
        segment_i         = ones_v;
        mon.frame_ready_i = 1'b1;
        m_reset();
        #12;
        check_all();
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // First frame after reset, all blank, commits on edge 4
        repeat (3) step(ones_v, 1'b1);
        chk("first_not_early", 32'(mon.frame_valid_o), 32'd0);
        step(ones_v, 1'b1);
        chk("first_frame_valid", 32'(mon.frame_valid_o), 32'd1);
        chk("first_frame_blank", 32'(mon.digit_blank_o), 32'h3F);
        chk("first_frame_hex", 32'(mon.hex_value_o), 32'h0);
        step(ones_v, 1'b1);
        chk("first_frame_pulse", 32'(mon.frame_valid_o), 32'd0);

        // Digits 0..5 held with ready low
        repeat (4) step(v_v, 1'b0);
        chk("v_not_early", 32'(mon.frame_valid_o), 32'd0);
        step(v_v, 1'b0);
        chk("v_frame_valid", 32'(mon.frame_valid_o), 32'd1);
        chk("v_hex", 32'(mon.hex_value_o), 32'h543210);
        chk("v_digit_valid", 32'(mon.digit_valid_o), 32'h3F);
        repeat (5) step(v_v, 1'b0);
        chk("v_held", 32'(mon.frame_valid_o), 32'd1);
        step(v_v, 1'b1);
        chk("v_accepted", 32'(mon.frame_valid_o), 32'd0);
        repeat (6) step(v_v, 1'b1);
        chk("v_no_repeat", 32'(mon.frame_valid_o), 32'd0);

        // Glitch on digit 0 that returns to the committed value
        repeat (2) step(g_v, 1'b1);
        repeat (8) step(v_v, 1'b1);
        chk("glitch_no_frame", 32'(mon.hex_value_o), 32'h543210);

        // Digit 0 becomes 'A'
        repeat (5) step(a_v, 1'b0);
        chk("a_frame_valid", 32'(mon.frame_valid_o), 32'd1);
        chk("a_nibble", 32'(mon.hex_value_o[3:0]), 32'hA);
        step(a_v, 1'b1);

        // Digit 2 shows 'H' (unknown glyph)
        repeat (6) step(h_v, 1'b0);
        chk("h_valid_bit", 32'(mon.digit_valid_o[2]), 32'd0);
        chk("h_blank_bit", 32'(mon.digit_blank_o[2]), 32'd0);
        chk("h_nibble", 32'(mon.hex_value_o[11:8]), 32'h0);

        // Change during PEND is held back until after the handshake
        repeat (6) step(e_v, 1'b0);
        chk("pend_old_value", 32'(mon.hex_value_o[7:4]), 32'h1);
        step(e_v, 1'b1);
        chk("pend_handshake", 32'(mon.frame_valid_o), 32'd0);
        step(e_v, 1'b0);
        chk("second_frame_valid", 32'(mon.frame_valid_o), 32'd1);
        chk("second_frame_nibble", 32'(mon.hex_value_o[7:4]), 32'h8);

        // Asynchronous reset while a frame is pending
        #2;
        rst_n_i = 1'b0;
        m_reset();
        #1;
        chk("async_rst_valid", 32'(mon.frame_valid_o), 32'd0);
        check_all();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (5) step(e_v, 1'b0);
        chk("rst_refirst_valid", 32'(mon.frame_valid_o), 32'd1);
        chk("rst_refirst_nibble", 32'(mon.hex_value_o[7:4]), 32'h8);
        step(e_v, 1'b1);

        // Randomized holds with occasional single-bit glitches and random ready
        for (int i = 0; i < 150; i++) begin
            rv = rnd_vec();
            for (int j = 0; j < int'($urandom_range(1, 8)); j++) begin
                gv = rv;
                if ($urandom_range(0, 9) == 0) begin
                    idx = int'($urandom_range(0, W - 1));
                    gv[idx] = ~gv[idx];
                end
                step(gv, 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_to_hex_decode_de1soc.md
# seg_to_hex_decode_de1soc

Reverse path of the DE1-SoC character-to-segment encoder. Samples active-low 7-segment buses driven to the HEX displays, filters glitches, decodes each digit back to a hex nibble (0-F) or blank, and emits one stable multi-digit frame per change over a valid/ready handshake. Used as an on-chip display monitor for self-checking and for readback over the debug UART.

## Interface
- `NUM_DIGITS`, default 6: number of 7-segment digits monitored (HEX0..HEX5).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit counts as stable; legal range 1..255.
- `clk_i`, input, 1: system clock; single clock domain.
- `rst_n_i`, input, 1: reset, asynchronous and active-low.
- `segment_i`, input, `NUM_DIGITS*7`: active-low segments. Digit k occupies bits [7k+6:7k]; bit 0 = seg a ... bit 6 = seg g.
- `hex_value_o`, output, `NUM_DIGITS*4`: committed nibbles; digit k at [4k+3:4k].
- `digit_valid_o`, output, `NUM_DIGITS`: digit k pattern recognised as a hex glyph.
- `digit_blank_o`, output, `NUM_DIGITS`: digit k is all segments off.
- `frame_valid_o`, output, 1: committed frame available.
- `frame_ready_i`, input, 1: consumer accepts the frame.

## Operation
- Per digit, the active-high pattern p is ~segment slice. Hex glyph table (p in hex): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Decode result:
  - Table hit: nibble as listed, valid=1, blank=0.
  - p=00: nibble=0, valid=0, blank=1.
  - Any other pattern: nibble=0, valid=0, blank=0 (unknown).
  - Aliased glyphs (O, S, etc.) always decode to their hex meaning.
- Per-digit filter, evaluated at every edge:
  - The sample register `seg_q` loads the digit's slice of `segment_i`.
  - Counter `cnt` (8 bit): if the incoming slice equals `seg_q`, `cnt` increments, saturating at STABLE_CYCLES-1; otherwise `cnt` resets to 0.
  - The digit is stable when `cnt == STABLE_CYCLES-1`.
- The frame is stable when all digits are stable.
- Snapshot: the decode of all `seg_q` values plus a raw copy of all `seg_q` values (`last_q`), used for change detection.
- FSM, states IDLE and PEND:
  - IDLE -> PEND when the frame is stable AND (`first_q`=1 OR the `seg_q` vector differs from `last_q`). In the same edge, load the output registers and `last_q`, clear `first_q`, and set `frame_valid_o`.
  - PEND -> IDLE when `frame_ready_i`=1. `frame_valid_o` clears.
  - Outputs hold constant while in PEND.
- Input changes during PEND keep updating the filters but are not committed. After returning to IDLE, the next commit can occur one edge later, and only if the stable value differs from `last_q`.
- Toggling that never settles produces no frame. An input that changes and returns to the committed value before re-stabilising produces no new frame.

## Timing
- Reset values:
  - All outputs 0; state IDLE.
  - `seg_q` = all ones (blank, active-low); `cnt` = 0; `last_q` = 0; `first_q` = 1.
- Latency: a value applied before edge 0 and held. Edge 0 loads `seg_q` and sets `cnt`=0. Edge S-1 makes the digit stable. Edge S commits and `frame_valid_o` is high after edge S (S = STABLE_CYCLES). For S=1, the commit is at edge 1.
- The first frame after reset is reported even if all digits are blank. It is committed at edge S after reset release, provided the input is steady.
- Handshake: transfer occurs on an edge where `frame_valid_o`=1 and `frame_ready_i`=1. Minimum spacing between frames is 2 cycles. `frame_ready_i` is ignored in IDLE.
- If `segment_i` changes on the commit edge, the commit still uses `seg_q`; the filter restarts from that edge.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). A pending frame is lost.

## Structure
- Package `seg_decode_pkg` holds:
  - Glyph constants SEG_0..SEG_F and SEG_BLANK (active-high, 7 bit).
  - `typedef enum logic {IDLE, PEND} mon_state_t`.
  - `typedef struct packed {logic [3:0] nibble; logic valid; logic blank;} digit_dec_t`.
- Sub-module `seg_digit_filter`, instantiated NUM_DIGITS times, contains:
  - the sample register and stability counter;
  - the combinational glyph decode.
  - Outputs: `stable`, `seg_q`, `digit_dec_t`.
- The top level holds the frame FSM, `last_q`, `first_q` and the output registers.

## Test plan
- Reset release, `segment_i` all ones, `frame_ready_i`=1, S=4 -> frame_valid pulses 1 cycle after edge 4; `digit_blank_o`=6'h3F, `digit_valid_o`=0, `hex_value_o`=0.
- Drive ~{3F,06,5B,4F,66,6D} (digits 0..5) held for 10 cycles, `frame_ready_i`=0 -> `frame_valid_o` high after edge 4 and held; `hex_value_o`=24'h543210, `digit_valid_o`=6'h3F. Then raise ready -> valid clears next edge; no further frame.
- Digit 0 glitches for 2 cycles (pattern 06), then returns to 3F -> no new frame. Digit 0 changes to 77 and is held -> frame with nibble 4'hA after S+1 edges.
- Digit 2 = ~7'h76 ('H'), held -> `digit_valid_o[2]`=0, `digit_blank_o[2]`=0, `hex_value_o[11:8]`=0.
- In PEND, change digit 1 to 7F and hold, then assert ready -> the first frame shows the old value; a second frame with nibble 8 is valid 2 edges after the handshake.
- `rst_n_i` asserted while PEND -> `frame_valid_o`=0 and all outputs 0 with no clock edge; after release, the first frame is reported again.
